oric_tape_encoder: RTL and testbench
====================================

// Module: oric_tape_encoder
// PURPOSE
//  Byte-to-audio tape modulator for the Oric core: transmit end of the cassette interface whose
//  receive end is the VIA/K7_TAPEIN path. Accepts bytes over valid/ready (from the TAP streamer)
//  and emits the Oric fast-format (2400 baud) bit-cell waveform for K7_TAPEIN, replacing the ADC.
//  Leader/sync bytes (0x16...) and header are the feeder's job; this block frames single bytes.
// PARAMETERS
//  CLK_HZ     24000000  input clock frequency in Hz
//  TICK_DIV   CLK_HZ/4800  clocks per half-period tick (~208 us)
//  STOP_BITS  4         number of '1' stop bits appended per byte (1..15)
// PORTS
//  clk        in   1  system clock (clk_sys)
//  reset_n    in   1  asynchronous, active-low reset
//  enable     in   1  tape motor/play; low aborts transmission
//  in_data    in   8  byte to transmit
//  in_valid   in   1  in_data valid
//  in_ready   out  1  block can accept a byte this cycle
//  tape_out   out  1  modulated tape level to K7_TAPEIN
//  busy       out  1  frame in progress
//  byte_done  out  1  one-cycle pulse when last stop bit completes
// BEHAVIOUR
//  Reset (async, reset_n=0): state IDLE, tape_out=0, in_ready=0, busy=0, byte_done=0,
//    tick counter/bit index/shift reg cleared.
//  Tick: counter runs 0..TICK_DIV-1, cleared on byte accept and on every phase entry.
//    One tick = TICK_DIV clocks exactly.
//  Bit cell: HIGH phase 1 tick, then LOW phase 1 tick for bit '1' or 2 ticks for bit '0'.
//  Frame (LSB first): start '0', d0..d7, parity P = ~^in_data (odd parity over data+P),
//    then STOP_BITS '1's. Length = 10+STOP_BITS bits.
//  FSM: IDLE -> HIGH on in_valid&in_ready (latch 10+STOP_BITS-bit frame into shift reg,
//    bit index=0). HIGH -> LOW after 1 tick. LOW -> HIGH (next bit) after 1 or 2 ticks.
//    After last bit's LOW: byte_done pulses 1 cycle and the FSM returns to IDLE.
//  in_ready = (state==IDLE) & enable. busy = (state!=IDLE). in_data is sampled only on accept;
//    later changes are ignored.
//  tape_out=1 in HIGH, 0 in LOW and IDLE. Latency: tape_out rises the cycle after accept.
//  Back-to-back: the next byte can be accepted in the IDLE cycle after byte_done, so the gap
//    between frames is 1 clock at tape_out=0.
//  enable low in any state: next cycle state=IDLE, tape_out=0, no byte_done,
//    partial frame discarded, in_ready=0.
//  enable low and in_valid high in the same cycle: the byte is not accepted.
//  Frame cycle count = TICK_DIV*(2*N1 + 3*N0), where N1/N0 = ones/zeros in the full frame.
// TESTING (CLK_HZ=48000 -> TICK_DIV=10, STOP_BITS=4)
//  1. Reset mid-frame (assert reset_n=0 while busy) -> tape_out=0, busy=0, in_ready=0
//     immediately; after release in_ready=1 with enable=1.
//  2. Send 0x00 -> P=1; bit periods 30,30x8,20,20x4 clocks; 370 clocks from accept to
//     byte_done; every high pulse exactly 10 clocks.
//  3. Send 0xFF -> P=1; start 30 clocks then 20-clock cells; byte_done 290 clocks after accept.
//  4. Send 0x01 then 0x03 with in_valid held -> P(0x01)=0, P(0x03)=1; second accept exactly
//     1 clock after first byte_done; decoded bits match the frame.
//  5. Drop enable during bit 4 of 0x5A -> tape_out=0 next cycle, no byte_done; re-enable and
//     send 0x5A -> full 330-clock frame.
//  6. Hold in_valid with enable=0 -> never accepted; in_data changes during a frame do not
//     alter the emitted bits.

Source files
------------

// File: rtl/oric_tape_encoder.sv
// Oric fast-format (2400 baud) tape modulator: frames one byte per handshake
// as start/data/odd-parity/stop bit cells on tape_out for the K7_TAPEIN path.
module oric_tape_encoder #(
  parameter int CLK_HZ    = 24000000,
  parameter int TICK_DIV  = CLK_HZ / 4800,
  parameter int STOP_BITS = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tape_out,
  output logic       busy,
  output logic       byte_done
);

  localparam int FRAME_LEN = 10 + STOP_BITS;
  localparam int CNT_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IDX_W     = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_HIGH, ST_LOW} state_t;

  state_t               state;
  state_t               state_next;
  logic [CNT_W-1:0]     tick_cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [FRAME_LEN-1:0] shift_reg;
  logic                 low_second;
  logic                 accept;
  logic                 tick_end;
  logic                 low_end;
  logic                 last_bit;

  // A '0' cell needs a second LOW tick; low_second marks that the first has elapsed.
  assign accept   = in_valid & in_ready;
  assign tick_end = (tick_cnt == TICK_LAST);
  assign low_end  = tick_end & (shift_reg[0] | low_second);
  assign last_bit = (bit_idx == LAST_IDX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept)   state_next = ST_HIGH;
      ST_HIGH: if (tick_end) state_next = ST_LOW;
      ST_LOW:  if (low_end)  state_next = last_bit ? ST_IDLE : ST_HIGH;
      default:               state_next = ST_IDLE;
    endcase
    if (!enable) begin
      state_next = ST_IDLE;
    end
  end

  always_comb begin
    in_ready  = (state == ST_IDLE) & enable & reset_n;
    busy      = (state != ST_IDLE);
    tape_out  = (state == ST_HIGH);
    byte_done = (state == ST_LOW) & low_end & last_bit & enable;
  end

  // Frame is shifted out LSB first; the current bit always sits in shift_reg[0].
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt   <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      low_second <= 1'b0;
    end else if (!enable) begin
      tick_cnt   <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      low_second <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            shift_reg  <= {{STOP_BITS{1'b1}}, ~^in_data, in_data, 1'b0};
            bit_idx    <= '0;
            tick_cnt   <= '0;
            low_second <= 1'b0;
          end
        end
        ST_HIGH: begin
          tick_cnt <= tick_end ? '0 : tick_cnt + CNT_W'(1);
        end
        ST_LOW: begin
          if (!tick_end) begin
            tick_cnt <= tick_cnt + CNT_W'(1);
          end else begin
            tick_cnt <= '0;
            if (low_end) begin
              low_second <= 1'b0;
              shift_reg  <= shift_reg >> 1;
              bit_idx    <= last_bit ? '0 : bit_idx + IDX_W'(1);
            end else begin
              low_second <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oric_tape_encoder.sv
// Scoreboard bench for oric_tape_encoder: a waveform-decoding monitor checks
// every emitted frame against a bit-level model of the Oric tape format.
module tb_oric_tape_encoder;

  localparam int CLK_HZ    = 48000;
  localparam int TICK_DIV  = CLK_HZ / 4800;
  localparam int STOP_BITS = 4;
  localparam int FRAME_LEN = 10 + STOP_BITS;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       tape_out;
  logic       busy;
  logic       byte_done;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] data;
    bit         abort;
    bit         b2b;
  } exp_t;

  exp_t sb_q[$];

  oric_tape_encoder #(
    .CLK_HZ(CLK_HZ),
    .TICK_DIV(TICK_DIV),
    .STOP_BITS(STOP_BITS)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .enable(enable),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .tape_out(tape_out),
    .busy(busy),
    .byte_done(byte_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, actual, actual,
               expected, expected);
    end
  endtask

  // Oric frame: start 0, data LSB first, odd parity, then stop ones.
  function automatic int modelBit(input logic [7:0] d, input int idx);
    if (idx == 0) return 0;
    if (idx <= 8) return int'(d[idx-1]);
    if (idx == 9) return ($countones(d) % 2 == 0) ? 1 : 0;
    return 1;
  endfunction

  function automatic int modelLength(input logic [7:0] d);
    int len = 0;
    for (int i = 0; i < FRAME_LEN; i++) begin
      len += (modelBit(d, i) == 1) ? 2 * TICK_DIV : 3 * TICK_DIV;
    end
    return len;
  endfunction

  // Monitor: decodes tape_out into bits by measuring HIGH and LOW run lengths.
  int   mon_cyc = 0;
  bit   in_frame = 0;
  bit   abort_check = 0;
  int   acc_cyc = 0;
  int   last_done = -100;
  int   high_cnt = 0;
  int   low_cnt = 0;
  int   n_dec = 0;
  int   dec_bits[32];
  exp_t cur;

  task automatic recordBit();
    int b;
    if (low_cnt == TICK_DIV) b = 1;
    else if (low_cnt == 2 * TICK_DIV) b = 0;
    else b = 2;
    if (n_dec < 32) dec_bits[n_dec] = b;
    n_dec++;
    low_cnt = 0;
  endtask

  task automatic finishFrame();
    logic [31:0] got_word;
    logic [31:0] exp_word;
    int          bad;
    got_word = '0;
    exp_word = '0;
    bad = 0;
    for (int i = 0; i < FRAME_LEN && i < n_dec; i++) begin
      if (dec_bits[i] == 2) bad++;
      got_word[i] = (dec_bits[i] == 1);
    end
    for (int i = 0; i < FRAME_LEN; i++) begin
      exp_word[i] = (modelBit(cur.data, i) == 1);
    end
    checkOutput("bit_count", n_dec, FRAME_LEN);
    checkOutput("bad_cell_widths", bad, 0);
    checkOutput("frame_bits", int'(got_word), int'(exp_word));
    checkOutput("accept_to_done", mon_cyc - acc_cyc, modelLength(cur.data));
    checkOutput("done_on_aborted_frame", int'(cur.abort), 0);
  endtask

  always @(negedge clk) begin
    mon_cyc++;
    checkOutput("in_ready_rule", int'(in_ready), int'(!busy && enable && reset_n));
    if (abort_check) begin
      abort_check = 0;
      checkOutput("abort_tape_out", int'(tape_out), 0);
      checkOutput("abort_busy", int'(busy), 0);
      checkOutput("abort_byte_done", int'(byte_done), 0);
    end
    if (in_frame && (!enable || !reset_n)) begin
      in_frame = 0;
      abort_check = 1;
      checkOutput("abort_expected", int'(cur.abort), 1);
      if (sb_q.size() > 0) void'(sb_q.pop_front());
    end else if (in_frame) begin
      if (tape_out) begin
        if (low_cnt > 0) recordBit();
        high_cnt++;
      end else begin
        if (high_cnt > 0) begin
          checkOutput("high_width", high_cnt, TICK_DIV);
          high_cnt = 0;
        end
        low_cnt++;
      end
      if (byte_done) begin
        recordBit();
        finishFrame();
        last_done = mon_cyc;
        in_frame = 0;
        if (sb_q.size() > 0) void'(sb_q.pop_front());
      end
    end else begin
      checkOutput("spurious_byte_done", int'(byte_done), 0);
    end
    if (in_valid && in_ready) begin
      if (sb_q.size() == 0 || in_frame) begin
        checkOutput("unexpected_accept", 1, 0);
      end else begin
        cur = sb_q[0];
        in_frame = 1;
        acc_cyc = mon_cyc;
        high_cnt = 0;
        low_cnt = 0;
        n_dec = 0;
        if (cur.b2b) checkOutput("b2b_accept_gap", mon_cyc - last_done, 1);
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] d, input bit abort, input bit b2b,
                               input bit hold);
    exp_t e;
    bit   got;
    e.data  = d;
    e.abort = abort;
    e.b2b   = b2b;
    sb_q.push_back(e);
    in_data  = d;
    in_valid = 1'b1;
    got = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (in_valid && in_ready) begin
        got = 1;
        break;
      end
    end
    if (!got) checkOutput("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    if (!hold) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
    end
  endtask

  task automatic waitIdle();
    bit done;
    done = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      if (!in_valid) in_data = 8'($urandom);
      if (sb_q.size() == 0 && !busy) begin
        done = 1;
        break;
      end
    end
    if (!done) checkOutput("idle_timeout", sb_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int busy_cycles;
    reset_n  = 1'b0;
    enable   = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    #2;
    checkOutput("reset_tape_out", int'(tape_out), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_in_ready", int'(in_ready), 0);
    checkOutput("reset_byte_done", int'(byte_done), 0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Reset in the middle of a frame
    applyStimulus(8'h3C, 1, 0, 0);
    repeat (40) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    checkOutput("midreset_tape_out", int'(tape_out), 0);
    checkOutput("midreset_busy", int'(busy), 0);
    checkOutput("midreset_in_ready", int'(in_ready), 0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("post_reset_in_ready", int'(in_ready), 1);
    checkOutput("post_reset_queue", sb_q.size(), 0);

    // All-zero and all-one bytes
    applyStimulus(8'h00, 0, 0, 0);
    waitIdle();
    applyStimulus(8'hFF, 0, 0, 0);
    waitIdle();

    // Back-to-back with in_valid held high
    applyStimulus(8'h01, 0, 0, 1);
    in_data = 8'h03;
    applyStimulus(8'h03, 0, 1, 0);
    waitIdle();

    // Drop enable during bit 4, then resend the same byte
    applyStimulus(8'h5A, 1, 0, 0);
    repeat (112) @(posedge clk);
    #1 enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("abort_queue", sb_q.size(), 0);
    enable = 1'b1;
    applyStimulus(8'h5A, 0, 0, 0);
    waitIdle();

    // in_valid held while disabled must never be accepted
    enable   = 1'b0;
    in_valid = 1'b1;
    busy_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1 in_data = 8'($urandom);
      @(negedge clk);
      if (busy) busy_cycles++;
    end
    checkOutput("disabled_busy_cycles", busy_cycles, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    enable   = 1'b1;

    // Random bytes, in_data scrambled while each frame is on tape
    for (int n = 0; n < 16; n++) begin
      applyStimulus(8'($urandom), 0, 0, 0);
      waitIdle();
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    repeat (5) @(posedge clk);
    checkOutput("final_queue_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
